// File: rtl/cdr_pattern_tx.sv
// NCO-timed PAM2/PAM4 pattern transmitter: preamble then PRBS7 payload on a signed 8-bit stream.
// Optional TX_ISI_EN adds a fixed one-tap post-cursor (prev_level >>> ISI_SHIFT) to each sample.
module cdr_pattern_tx #(
    parameter int unsigned           PHASE_BITS   = 32,
    parameter logic [PHASE_BITS-1:0] FCW_NOM      = 32'h8000_0000,
    parameter int unsigned           PREAMBLE_LEN = 32,
    parameter int                    AMP2         = 64,
    parameter int                    LVL4         = 21,
    parameter int unsigned           ISI_SHIFT    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              pam4,
    input  logic signed [15:0] fcw_trim,
    input  logic              inject_err,
    output logic signed [7:0] y_n,
    output logic              sym_strobe,
    output logic [1:0]        tx_bits,
    output logic              busy,
    output logic              in_payload,
    output logic [15:0]       sym_cnt
);

    typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD} state_t;

    localparam logic signed [9:0] A2 = 10'(AMP2);
    localparam logic signed [9:0] L1 = 10'(LVL4);
    localparam logic signed [9:0] L3 = 10'(3 * LVL4);
    localparam logic [15:0]       PRE_LAST = 16'(PREAMBLE_LEN - 1);

    state_t                state, state_nx;
    logic [PHASE_BITS-1:0] phase, phase_sum, fcw;
    logic                  carry, boundary, last_pre;
    logic [15:0]           pre_cnt;
    logic [6:0]            lfsr, lfsr_nx;
    logic                  err_pend;
    logic [1:0]            sym_bits;
    logic signed [9:0]     level;
    logic signed [10:0]    sum_w;

    function automatic logic [6:0] prbs_step(input logic [6:0] s);
        return {s[5:0], s[6] ^ s[5]};
    endfunction

    function automatic logic signed [9:0] map_level(input logic p4, input logic [1:0] b);
        if (p4) begin
            case (b)
                2'b00:   return -L3;
                2'b01:   return -L1;
                2'b11:   return L1;
                default: return L3;
            endcase
        end
        return b[0] ? A2 : -A2;
    endfunction

    function automatic logic signed [7:0] sat8(input logic signed [10:0] v);
        if (v > 11'sd127)  return 8'sd127;
        if (v < -11'sd128) return -8'sd128;
        return v[7:0];
    endfunction

    assign fcw                = FCW_NOM + {{(PHASE_BITS-16){fcw_trim[15]}}, fcw_trim};
    assign {carry, phase_sum} = {1'b0, phase} + {1'b0, fcw};
    assign boundary           = carry && (state != IDLE);
    assign last_pre           = (pre_cnt == PRE_LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:     if (en) state_nx = PREAMBLE;
            PREAMBLE: if (boundary) state_nx = !en ? IDLE : (last_pre ? PAYLOAD : PREAMBLE);
            PAYLOAD:  if (boundary && !en) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // Next symbol contents; only registered on a boundary, so pam4 is effectively sampled there.
    always_comb begin
        busy       = (state != IDLE);
        in_payload = (state == PAYLOAD);
        sym_bits   = '0;
        lfsr_nx    = lfsr;
        unique case (state)
            PREAMBLE: sym_bits = pam4 ? {~pre_cnt[0], 1'b0} : {1'b0, ~pre_cnt[0]};
            PAYLOAD: begin
                if (pam4) begin
                    sym_bits = {lfsr[6], lfsr[5]};
                    lfsr_nx  = prbs_step(prbs_step(lfsr));
                end else begin
                    sym_bits = {1'b0, lfsr[6]};
                    lfsr_nx  = prbs_step(lfsr);
                end
                sym_bits[0] = sym_bits[0] ^ err_pend;
            end
            default: sym_bits = '0;
        endcase
        level = map_level(pam4, sym_bits);
    end

`ifdef TX_ISI_EN
    logic signed [9:0] prev_level, tap;
    assign tap   = prev_level >>> ISI_SHIFT;
    assign sum_w = {level[9], level} + {tap[9], tap};
`else
    assign sum_w = {level[9], level};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            phase      <= '0;
            lfsr       <= '1;
            err_pend   <= 1'b0;
            pre_cnt    <= '0;
            y_n        <= '0;
            sym_strobe <= 1'b0;
            tx_bits    <= '0;
            sym_cnt    <= '0;
`ifdef TX_ISI_EN
            prev_level <= '0;
`endif
        end else begin
            sym_strobe <= 1'b0;
            if (state == IDLE) begin
                phase    <= '0;
                err_pend <= 1'b0;
                pre_cnt  <= '0;
                y_n      <= '0;
                tx_bits  <= '0;
`ifdef TX_ISI_EN
                prev_level <= '0;
`endif
                if (en) begin
                    sym_cnt <= '0;
                    lfsr    <= '1;
                end
            end else if (boundary && !en) begin
                phase    <= '0;
                err_pend <= 1'b0;
                y_n      <= '0;
                tx_bits  <= '0;
`ifdef TX_ISI_EN
                prev_level <= '0;
`endif
            end else begin
                phase <= phase_sum;
                // A pulse landing on a payload boundary arms the symbol after this one.
                if (boundary && state == PAYLOAD) err_pend <= inject_err;
                else                              err_pend <= err_pend | inject_err;
                if (boundary) begin
                    y_n        <= sat8(sum_w);
                    tx_bits    <= sym_bits;
                    sym_strobe <= 1'b1;
                    lfsr       <= lfsr_nx;
`ifdef TX_ISI_EN
                    prev_level <= level;
`endif
                    if (state == PREAMBLE) pre_cnt <= pre_cnt + 16'd1;
                    if (state == PAYLOAD && sym_cnt != 16'hFFFF) sym_cnt <= sym_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cdr_pattern_tx.sv
// Scoreboard bench for cdr_pattern_tx: expected symbols are queued from a reference model and
// popped on each sym_strobe.
module tb_cdr_pattern_tx;

    logic        clk = 1'b0;
    logic        rst, en, pam4, inject_err;
    logic signed [15:0] fcw_trim;
    logic [7:0]  y_n;
    logic        sym_strobe, busy, in_payload;
    logic [1:0]  tx_bits;
    logic [15:0] sym_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [7:0] y;
        logic [1:0] bits;
    } exp_t;
    exp_t exp_q[$];

    logic [6:0] m_lfsr;
    int         m_prev;

    cdr_pattern_tx dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .pam4       (pam4),
        .fcw_trim   (fcw_trim),
        .inject_err (inject_err),
        .y_n        (y_n),
        .sym_strobe (sym_strobe),
        .tx_bits    (tx_bits),
        .busy       (busy),
        .in_payload (in_payload),
        .sym_cnt    (sym_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] m_step(input logic [6:0] s);
        return {s[5:0], s[6] ^ s[5]};
    endfunction

    task automatic push_sym(input bit p4, input logic [1:0] b);
        int lvl, y;
        exp_t e;
        if (p4) begin
            case (b)
                2'b00:   lvl = -63;
                2'b01:   lvl = -21;
                2'b11:   lvl = 21;
                default: lvl = 63;
            endcase
        end else begin
            lvl = b[0] ? 64 : -64;
        end
        y = lvl;
`ifdef TX_ISI_EN
        y = lvl + (m_prev >>> 2);
        if (y > 127)  y = 127;
        if (y < -128) y = -128;
`endif
        m_prev = lvl;
        e.y    = y[7:0];
        e.bits = b;
        exp_q.push_back(e);
    endtask

    task automatic push_run(input bit p4, input int n_pay, input int flip0, input int flip1);
        logic [1:0] b;
        m_prev = 0;
        m_lfsr = 7'h7F;
        for (int i = 0; i < 32; i++) begin
            b = p4 ? {(i % 2 == 0), 1'b0} : {1'b0, (i % 2 == 0)};
            push_sym(p4, b);
        end
        for (int j = 0; j < n_pay; j++) begin
            if (p4) begin
                b      = {m_lfsr[6], m_lfsr[5]};
                m_lfsr = m_step(m_step(m_lfsr));
            end else begin
                b      = {1'b0, m_lfsr[6]};
                m_lfsr = m_step(m_lfsr);
            end
            if (j == flip0 || j == flip1) b[0] = ~b[0];
            push_sym(p4, b);
        end
    endtask

    // pulse_cyc 0: inject on the mid-UI edge before the first symbol; 1: on its boundary edge.
    task automatic consume(input int n, input int pulse_cyc);
        int   cyc;
        bit   got;
        exp_t e;
        for (int k = 0; k < n; k++) begin
            cyc = 0;
            got = 1'b0;
            while (!got && cyc < 16) begin
                inject_err = (k == 0 && cyc == pulse_cyc);
                @(negedge clk);
                cyc++;
                got = sym_strobe;
            end
            inject_err = 1'b0;
            if (!got) begin
                chk("strobe_timeout", 32'd0, 32'd1);
                return;
            end
            chk("strobe_gap", cyc, 32'd2);
            if (exp_q.size() == 0) begin
                chk("queue_underflow", 32'd0, 32'd1);
                return;
            end
            e = exp_q.pop_front();
            chk("y_n", {24'h0, y_n}, {24'h0, e.y});
            chk("tx_bits", {30'h0, tx_bits}, {30'h0, e.bits});
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_y_n"}, {24'h0, y_n}, 32'd0);
        chk({tag, "_strobe"}, {31'h0, sym_strobe}, 32'd0);
        chk({tag, "_tx_bits"}, {30'h0, tx_bits}, 32'd0);
        chk({tag, "_busy"}, {31'h0, busy}, 32'd0);
        chk({tag, "_in_payload"}, {31'h0, in_payload}, 32'd0);
    endtask

    initial begin
        int          cnt;
        longint      exp_cnt;
        rst        = 1'b1;
        en         = 1'b0;
        pam4       = 1'b0;
        fcw_trim   = '0;
        inject_err = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        chk("reset_sym_cnt", {16'h0, sym_cnt}, 32'd0);

        // PAM2 preamble then two full PRBS7 periods
        rst = 1'b0;
        push_run(1'b0, 254, -1, -1);
        en = 1'b1;
        @(negedge clk);
        chk("start_busy", {31'h0, busy}, 32'd1);
        chk("start_in_payload", {31'h0, in_payload}, 32'd0);
        consume(32, -1);
        chk("pre_done_in_payload", {31'h0, in_payload}, 32'd1);
        chk("pre_done_sym_cnt", {16'h0, sym_cnt}, 32'd0);
        consume(254, -1);
        chk("pam2_sym_cnt", {16'h0, sym_cnt}, 32'd254);

        // Drop en mid-UI: one strobe-free clock, then IDLE at the boundary
        en = 1'b0;
        @(negedge clk);
        chk("drop_en_no_strobe", {31'h0, sym_strobe}, 32'd0);
        chk("drop_en_still_busy", {31'h0, busy}, 32'd1);
        @(negedge clk);
        chk_all_zero("drop_en_idle");
        chk("drop_en_sym_cnt_kept", {16'h0, sym_cnt}, 32'd254);
        exp_q.delete();

        // PAM4 preamble and payload
        pam4 = 1'b1;
        push_run(1'b1, 60, -1, -1);
        en = 1'b1;
        @(negedge clk);
        consume(92, -1);
        chk("pam4_sym_cnt", {16'h0, sym_cnt}, 32'd60);

        // Reset in the middle of PAYLOAD
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("rst_payload");
        chk("rst_payload_sym_cnt", {16'h0, sym_cnt}, 32'd0);
        en   = 1'b0;
        pam4 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();

        // Error injection: two preamble pulses flip only payload 0; boundary pulse flips 13
        push_run(1'b0, 40, 0, 13);
        en = 1'b1;
        @(negedge clk);
        consume(5, -1);
        consume(1, 0);
        consume(3, -1);
        consume(1, 1);
        consume(22, -1);
        consume(12, -1);
        consume(1, 1);
        consume(27, -1);
        chk("inject_queue_drained", exp_q.size(), 32'd0);

        rst = 1'b1;
        en  = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Positive trim: strobe rate over 10k clocks
        fcw_trim = 16'sh7FFF;
        en = 1'b1;
        @(negedge clk);
        cnt = 0;
        repeat (10000) begin
            @(negedge clk);
            if (sym_strobe) cnt++;
        end
        exp_cnt = (64'd10000 * (64'h8000_0000 + 64'd32767)) >> 32;
        chk("trim_strobe_count",
            ((longint'(cnt) >= exp_cnt - 1) && (longint'(cnt) <= exp_cnt + 1)) ? 32'(exp_cnt) : cnt,
            32'(exp_cnt));
        en = 1'b0;
        repeat (3) @(negedge clk);
        chk("trim_end_idle", {31'h0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
